hs32_regctl: RTL and testbench

Register-file access controller for the HS32 core, on the client side of the dual-port register file (`hs32_reg`). It accepts operand-read requests and writeback requests from the pipeline and arbitrates them onto the register file's shared write-enable/read timing. It captures the registered read data into a response buffer with valid/ready handshakes. It sits between decode/execute and the register file, which the parent instantiates.

---
 rtl/hs32_regctl_pkg.sv | 14 +
 rtl/hs32_regctl.sv | 104 ++++++++++
 tb/tb_hs32_regctl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs32_regctl_pkg.sv
// hs32_regctl shared types and defaults.
// FSM encodings and default widths for the regfile client.
package hs32_regctl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/hs32_regctl.sv
// hs32_regctl: arbitrates operand reads and writebacks
// onto the hs32_reg ports and buffers read responses.
module hs32_regctl
  import hs32_regctl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_a,
  input  logic [ADDR_WIDTH-1:0] rd_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_a,
  output logic [DATA_WIDTH-1:0] rsp_b,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wadr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_radr1,
  output logic [ADDR_WIDTH-1:0] rf_radr2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2
);

  state_t                state;
  logic                  last_wr;
  logic [ADDR_WIDTH-1:0] radr1_q;
  logic [ADDR_WIDTH-1:0] radr2_q;
  logic                  rd_can;
  logic                  rd_gnt;
  logic                  wb_gnt;

  // Grant logic: write wins contention unless it won last.
  always_comb begin
    rd_can = (state == S_IDLE) ||
             ((state == S_HOLD) && rsp_ready);
    rd_gnt = reset && rd_valid && rd_can &&
             (!wb_valid || last_wr);
    wb_gnt = reset && wb_valid && !rd_gnt;
  end

  assign rd_ready = rd_gnt;
  assign wb_ready = reset && !rd_gnt;
  assign rf_we    = wb_gnt;
  assign rf_wadr  = wb_adr;
  assign rf_din   = wb_data;
  assign rf_radr1 = rd_gnt ? rd_a : radr1_q;
  assign rf_radr2 = rd_gnt ? rd_b : radr2_q;

  // Fairness flag and held read addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_wr <= 1'b0;
      radr1_q <= '0;
      radr2_q <= '0;
    end else if (rd_gnt) begin
      last_wr <= 1'b0;
      radr1_q <= rd_a;
      radr2_q <= rd_b;
    end else if (wb_gnt) begin
      last_wr <= 1'b1;
    end
  end

  // Read FSM with registered response buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rd_gnt) state <= S_FETCH;
        end
        S_FETCH: begin
          rsp_a     <= rf_dout1;
          rsp_b     <= rf_dout2;
          rsp_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= rd_gnt ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_regctl.sv
// Directed bench for hs32_regctl with a behavioural
// hs32_reg model attached to the regfile ports.
module tb_hs32_regctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  rd_a;
  logic [3:0]  rd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_adr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [3:0]  rf_wadr;
  logic [31:0] rf_din;
  logic [3:0]  rf_radr1;
  logic [3:0]  rf_radr2;
  logic [31:0] rf_dout1;
  logic [31:0] rf_dout2;

  logic [31:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Register file model: write or registered read per cycle.
  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_wadr] <= rf_din;
    end else begin
      rf_dout1 <= mem[rf_radr1];
      rf_dout2 <= mem[rf_radr2];
    end
  end

  hs32_regctl dut (
    .clk       (clk),
    .reset     (reset),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_adr    (wb_adr),
    .wb_data   (wb_data),
    .rf_we     (rf_we),
    .rf_wadr   (rf_wadr),
    .rf_din    (rf_din),
    .rf_radr1  (rf_radr1),
    .rf_radr2  (rf_radr2),
    .rf_dout1  (rf_dout1),
    .rf_dout2  (rf_dout2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rv,
                     input logic [3:0] a,
                     input logic [3:0] b,
                     input logic wv,
                     input logic [3:0] wa,
                     input logic [31:0] wd,
                     input logic rr);
    rd_valid  = rv;
    rd_a      = a;
    rd_b      = b;
    wb_valid  = wv;
    wb_adr    = wa;
    wb_data   = wd;
    rsp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drv(1, 4'd1, 4'd2, 1, 4'd4, 32'h5, 0);
    #2;
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_a", rsp_a, 32'd0);
    chk("rst_rsp_b", rsp_b, 32'd0);
    #10;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    step();

    // preload r0
    drv(0, 0, 0, 1, 4'd0, 32'hA5A5_0000, 0);
    mid();
    chk("w0_we", {31'd0, rf_we}, 32'd1);
    step();

    // write r3 then read (3,3)
    drv(0, 0, 0, 1, 4'd3, 32'hDEAD_BEEF, 0);
    mid();
    chk("w3_we", {31'd0, rf_we}, 32'd1);
    chk("w3_wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("w3_wadr", {28'd0, rf_wadr}, 32'd3);
    chk("w3_din", rf_din, 32'hDEAD_BEEF);
    step();
    drv(1, 4'd3, 4'd3, 0, 0, 0, 0);
    mid();
    chk("r3_rd_ready", {31'd0, rd_ready}, 32'd1);
    chk("r3_we", {31'd0, rf_we}, 32'd0);
    chk("r3_radr1", {28'd0, rf_radr1}, 32'd3);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("r3_fetch_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    mid();
    chk("r3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("r3_rsp_a", rsp_a, 32'hDEAD_BEEF);
    chk("r3_rsp_b", rsp_b, 32'hDEAD_BEEF);
    step();

    // backpressure with writes hammering r3
    for (int i = 0; i < 5; i++) begin
      drv(1, 4'd5, 4'd5, 1, 4'd3, i, 0);
      mid();
      chk("bp_rd_ready", {31'd0, rd_ready}, 32'd0);
      chk("bp_we", {31'd0, rf_we}, 32'd1);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_a", rsp_a, 32'hDEAD_BEEF);
      chk("bp_rsp_b", rsp_b, 32'hDEAD_BEEF);
      chk("bp_radr_held", {28'd0, rf_radr1}, 32'd3);
      step();
    end
    drv(1, 4'd3, 4'd3, 0, 0, 0, 1);
    mid();
    chk("bp_release_rd", {31'd0, rd_ready}, 32'd1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("bp2_fetch_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    mid();
    chk("bp2_rsp_a", rsp_a, 32'd4);
    step();
    drv(0, 0, 0, 0, 0, 0, 1);
    step();

    // RAW ordering on r5
    drv(0, 0, 0, 1, 4'd5, 32'd1, 0);
    step();
    drv(1, 4'd5, 4'd5, 0, 0, 0, 0);
    mid();
    chk("raw_rd_ready", {31'd0, rd_ready}, 32'd1);
    step();
    drv(0, 0, 0, 1, 4'd5, 32'd2, 0);
    mid();
    chk("raw_fetch_we", {31'd0, rf_we}, 32'd1);
    step();
    drv(1, 4'd5, 4'd5, 0, 0, 0, 1);
    mid();
    chk("raw_old_valid", {31'd0, rsp_valid}, 32'd1);
    chk("raw_old_a", rsp_a, 32'd1);
    chk("raw_hold_rd", {31'd0, rd_ready}, 32'd1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    mid();
    chk("raw_new_a", rsp_a, 32'd2);
    step();
    drv(0, 0, 0, 0, 0, 0, 1);
    step();

    // dual address read
    drv(0, 0, 0, 1, 4'd1, 32'h11, 0);
    step();
    drv(0, 0, 0, 1, 4'd2, 32'h22, 0);
    step();
    drv(1, 4'd1, 4'd2, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    mid();
    chk("dual_a", rsp_a, 32'h11);
    chk("dual_b", rsp_b, 32'h22);
    step();
    drv(0, 0, 0, 0, 0, 0, 1);
    step();

    // contention: W,R,W,R...
    for (int i = 0; i < 8; i++) begin
      drv(1, 4'd7, 4'd7, 1, 4'd7, 32'h100 + i, 1);
      mid();
      chk("cont_rd_ready", {31'd0, rd_ready}, i % 2);
      chk("cont_we", {31'd0, rf_we}, (i % 2) ^ 1);
      chk("cont_wb_ready", {31'd0, wb_ready}, (i % 2) ^ 1);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 1);
    step();
    mid();
    chk("cont_valid", {31'd0, rsp_valid}, 32'd1);
    chk("cont_rsp_a", rsp_a, 32'h106);
    step();

    // reset during FETCH
    drv(1, 4'd0, 4'd0, 0, 0, 0, 0);
    mid();
    chk("rr_rd_ready", {31'd0, rd_ready}, 32'd1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rr_in_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rr_in_wb_ready", {31'd0, wb_ready}, 32'd0);
    mid();
    reset = 1'b1;
    step();
    mid();
    chk("rr_post_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    mid();
    chk("rr_post_valid2", {31'd0, rsp_valid}, 32'd0);
    step();
    drv(1, 4'd0, 4'd0, 0, 0, 0, 0);
    mid();
    chk("rr_idle_rd", {31'd0, rd_ready}, 32'd1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    mid();
    chk("rr_r0_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rr_r0_a", rsp_a, 32'hA5A5_0000);
    step();
    drv(0, 0, 0, 0, 0, 0, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
